// File: rtl/ser2par_loader.sv
// ser2par_loader: collects MSB-first serial bits into WIDTH-bit words and
// hands each completed word to a downstream register bank.
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   clk_en             - clock enable; all state holds while low
//   sin, sin_valid     - serial bit and its qualifier
//   pout_ready         - downstream accepts pout this cycle
//   ovf_clr            - clears the sticky overflow flag
//   pout, pout_valid   - last completed word and its unconsumed flag
//   busy               - state is not IDLE
//   bit_cnt            - bits captured in the current word
//   ovf                - sticky: a valid serial bit was dropped
module ser2par_loader #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             pout_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             busy,
  output logic [4:0]       bit_cnt,
  output logic             ovf
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d, shifted;
  logic [WIDTH-1:0]   pout_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;
  logic               last_bit;

  // Candidate shift-register value with sin entering at bit 0
  assign shifted  = {sreg_q[WIDTH-2:0], sin};
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // State and datapath registers; flags track the next state so they stay Moore-exact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      pout       <= '0;
      bit_cnt    <= '0;
      ovf        <= 1'b0;
      pout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      pout       <= pout_d;
      bit_cnt    <= cnt_d;
      ovf        <= ovf_d;
      pout_valid <= (state_d == FULL);
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        IDLE:    if (sin_valid) state_d = SHIFT;
        SHIFT:   if (sin_valid && last_bit) state_d = FULL;
        FULL:    if (pout_ready) state_d = sin_valid ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and flag updates
  always_comb begin
    sreg_d = sreg_q;
    pout_d = pout;
    cnt_d  = bit_cnt;
    ovf_d  = ovf;
    if (clk_en) begin
      if (ovf_clr) ovf_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (sin_valid) begin
            sreg_d = shifted;
            cnt_d  = CNT_W'(1);
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            sreg_d = shifted;
            cnt_d  = bit_cnt + CNT_W'(1);
            if (last_bit) pout_d = shifted;
          end
        end
        FULL: begin
          if (pout_ready) begin
            // Handoff: the word is consumed and this edge's bit starts the next word
            if (sin_valid) begin
              sreg_d = shifted;
              cnt_d  = CNT_W'(1);
            end else begin
              cnt_d  = '0;
            end
          end else if (sin_valid) begin
            ovf_d = 1'b1;  // set beats a coincident clear
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser2par_loader.sv
module tb_ser2par_loader;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             sin;
  logic             sin_valid;
  logic             pout_ready;
  logic             ovf_clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             busy;
  logic [4:0]       bit_cnt;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  ser2par_loader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .pout_ready (pout_ready),
    .ovf_clr    (ovf_clr),
    .pout       (pout),
    .pout_valid (pout_valid),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drv(input logic en, input logic sv, input logic s,
                     input logic rdy, input logic clr);
    clk_en     = en;
    sin_valid  = sv;
    sin        = s;
    pout_ready = rdy;
    ovf_clr    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_pout, input logic e_pv,
                         input logic e_busy, input logic [4:0] e_cnt, input logic e_ovf);
    chk({tag, ".pout"},       32'(pout),       32'(e_pout));
    chk({tag, ".pout_valid"}, 32'(pout_valid), 32'(e_pv));
    chk({tag, ".busy"},       32'(busy),       32'(e_busy));
    chk({tag, ".bit_cnt"},    32'(bit_cnt),    32'(e_cnt));
    chk({tag, ".ovf"},        32'(ovf),        32'(e_ovf));
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk_all("reset", 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Word 1011 with downstream stalled
    drv(1, 1, 1, 0, 0); tick();
    chk_all("w1011_b1", 4'h0, 1'b0, 1'b1, 5'd1, 1'b0);
    drv(1, 1, 0, 0, 0); tick();
    drv(1, 1, 1, 0, 0); tick();
    chk("w1011_b3.cnt", 32'(bit_cnt), 32'd3);
    drv(1, 1, 1, 0, 0); tick();
    chk_all("w1011_full", 4'b1011, 1'b1, 1'b1, 5'd4, 1'b0);

    // Hold FULL three cycles, then drain with no new bit
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_all("hold_full", 4'b1011, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(1, 0, 0, 1, 0); tick();
    chk_all("drain", 4'b1011, 1'b0, 1'b0, 5'd0, 1'b0);

    // Word 1100, then overflow tests
    drv(1, 1, 1, 0, 0); tick();
    drv(1, 1, 1, 0, 0); tick();
    drv(1, 1, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 0); tick();
    chk_all("w1100_full", 4'b1100, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(1, 1, 1, 0, 1); tick();   // drop coinciding with clear: set wins
    chk_all("ovf_set_wins", 4'b1100, 1'b1, 1'b1, 5'd4, 1'b1);
    drv(1, 0, 0, 0, 0); tick();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    drv(1, 0, 0, 0, 1); tick();
    chk_all("ovf_clr", 4'b1100, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(0, 1, 1, 0, 0); tick();   // disabled: no overflow
    chk("en0_no_ovf", 32'(ovf), 32'd0);
    drv(0, 0, 0, 1, 0); tick();   // disabled: no handoff
    chk("en0_no_drain", 32'(pout_valid), 32'd1);
    drv(1, 0, 0, 1, 0); tick();
    chk_all("drain2", 4'b1100, 1'b0, 1'b0, 5'd0, 1'b0);

    // Back-to-back 1011 then 0110; pout_ready high throughout is ignored in SHIFT
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 1, 0, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    chk("stream_shift_ready", 32'(pout_valid), 32'd0);
    drv(1, 1, 1, 1, 0); tick();
    chk_all("stream_full1", 4'b1011, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(1, 1, 0, 1, 0); tick();
    chk_all("stream_handoff", 4'b1011, 1'b0, 1'b1, 5'd1, 1'b0);
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    chk("stream_b3.cnt", 32'(bit_cnt), 32'd3);
    drv(1, 1, 0, 1, 0); tick();
    chk_all("stream_full2", 4'b0110, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(1, 0, 0, 1, 0); tick();
    chk_all("drain3", 4'b0110, 1'b0, 1'b0, 5'd0, 1'b0);

    // Clock-enable freeze mid-word
    drv(1, 1, 1, 0, 0); tick();
    drv(1, 1, 0, 0, 0); tick();
    chk("freeze_pre.cnt", 32'(bit_cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 1'(i % 2), 1'b1, 1'b1, 1'b1);
      tick();
    end
    chk_all("freeze", 4'b0110, 1'b0, 1'b1, 5'd2, 1'b0);
    drv(1, 1, 0, 0, 0); tick();
    drv(1, 1, 1, 0, 0); tick();
    chk_all("freeze_resume", 4'b1001, 1'b1, 1'b1, 5'd4, 1'b0);
    drv(1, 0, 0, 1, 0); tick();

    // Asynchronous reset mid-word
    drv(1, 1, 1, 0, 0); tick();
    drv(1, 1, 1, 0, 0); tick();
    chk("prerst.cnt", 32'(bit_cnt), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk_all("async_rst", 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1 reset = 1'b0;
    drv(1, 1, 0, 0, 0); tick();
    chk_all("post_rst_b1", 4'h0, 1'b0, 1'b1, 5'd1, 1'b0);
    drv(1, 1, 1, 0, 0); tick();
    drv(1, 1, 0, 0, 0); tick();
    drv(1, 1, 1, 0, 0); tick();
    chk_all("post_rst_full", 4'b0101, 1'b1, 1'b1, 5'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser2par_loader.md
SER2PAR_LOADER -- requirements
Module: ser2par_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4, parallel word width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clk_en  input  1  clock enable; when 0, the block holds all state.
REQ-005 SHALL have port sin  input  1  serial data bit.
REQ-006 SHALL have port sin_valid  input  1  sin is valid this cycle.
REQ-007 SHALL have port pout_ready  input  1  downstream register bank accepts pout this cycle.
REQ-008 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port pout  output  WIDTH  last completed parallel word.
REQ-010 SHALL have port pout_valid  output  1  pout holds an unconsumed word.
REQ-011 SHALL have port busy  output  1  state is not IDLE.
REQ-012 SHALL have port bit_cnt  output  5  bits captured in the current word.
REQ-013 SHALL have port ovf  output  1  sticky flag: a valid serial bit was dropped.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and FULL; all state and register updates occur only on a rising clk edge with clk_en=1.
REQ-015 SHALL, in IDLE with sin_valid=1, shift sin into the internal shift register, set bit_cnt=1, and go to SHIFT (go directly to FULL never, since WIDTH>=2).
REQ-016 SHALL, in SHIFT with sin_valid=1, shift left and insert sin at bit 0, then increment bit_cnt.
REQ-017 SHALL, in SHIFT with sin_valid=0, hold the shift register, bit_cnt and state.
REQ-018 SHALL order bits MSB-first: the first bit of a word lands in pout[WIDTH-1] and the last in pout[0].
REQ-019 SHALL, on the edge that accepts the WIDTH-th bit, load pout with the completed word, set bit_cnt=WIDTH, and enter FULL (latency: pout_valid rises on that same edge).
REQ-020 SHALL drive pout_valid=1 exactly while in FULL (Moore output); pout SHALL change only on entry to FULL and SHALL otherwise hold its last word.
REQ-021 SHALL, in FULL with pout_ready=1 and sin_valid=0, go to IDLE with bit_cnt=0.
REQ-022 SHALL, in FULL with pout_ready=1 and sin_valid=1, consume the word and capture sin as bit 1 of the next word (bit_cnt=1, go to SHIFT) with no overflow, allowing back-to-back words with no gap.
REQ-023 SHALL, in FULL with pout_ready=0 and sin_valid=1, drop the bit, set ovf=1, and leave pout, bit_cnt and state unchanged.
REQ-024 SHALL hold ovf until ovf_clr=1 on an enabled edge; if an overflow and ovf_clr coincide, the set SHALL win.
REQ-025 SHALL ignore sin_valid, pout_ready and ovf_clr while clk_en=0: no shift, no handoff, no overflow.
REQ-026 SHALL ignore pout_ready in IDLE and SHIFT.

Reset
REQ-027 SHALL, while reset=1, immediately and without a clock force state=IDLE, shift register=0, pout=0, pout_valid=0, busy=0, bit_cnt=0 and ovf=0.
REQ-028 SHALL discard a partial word when reset asserts mid-word; the first enabled edge after reset deasserts SHALL treat sin as bit 1 of a new word.

Verification (WIDTH=4)
REQ-029 SHALL cover: sin 1,0,1,1 on four consecutive enabled edges with pout_ready=0 -> after the 4th edge pout=4'b1011, pout_valid=1, bit_cnt=4, busy=1.
REQ-030 SHALL cover: hold FULL with pout_ready=0 for 3 cycles, then pout_ready=1 with sin_valid=0 -> pout_valid=0 and bit_cnt=0 after the next edge, with pout still equal to 4'b1011.
REQ-031 SHALL cover: in FULL, sin_valid=1 with pout_ready=0 -> ovf=1 and pout unchanged; then ovf_clr=1 -> ovf=0 after the next edge.
REQ-032 SHALL cover: a continuous stream of 1011 then 0110 with pout_ready=1 on the handoff edge -> no overflow, bit_cnt=1 after the handoff, and pout=4'b0110 with pout_valid=1 four edges after the first FULL.
REQ-033 SHALL cover: after 2 bits, clk_en=0 for 5 cycles while sin_valid toggles -> bit_cnt stays 2; resuming with 2 more bits completes the word correctly.
REQ-034 SHALL cover: reset pulsed between clock edges after 2 bits -> all outputs read 0 before the next edge, and the next 4 bits form a fresh word.
